// File: rtl/scan_peak_emulator.sv
// Scan-cycle stimulus generator: a ramp-start pulse plus three peak pulses at programmed
// offsets, and the intervals the downstream peak-interval timer is expected to measure.
module scan_peak_emulator #(
   parameter int DATA_WIDTH  = 24,
   parameter int COUNT_WIDTH = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   enable,
   input  logic                   cfg_valid,
   output logic                   cfg_ready,
   input  logic [DATA_WIDTH-1:0]  cfg_period,
   input  logic [DATA_WIDTH-1:0]  cfg_peak0,
   input  logic [DATA_WIDTH-1:0]  cfg_peak1,
   input  logic [DATA_WIDTH-1:0]  cfg_peak2,
   output logic                   cfg_error,
   output logic                   piezo_ramp_trigger,
   output logic                   peak_trigger,
   output logic [DATA_WIDTH-1:0]  exp_sm_cycle,
   output logic [DATA_WIDTH-1:0]  exp_Mm_cycle,
   output logic                   exp_valid,
   output logic [COUNT_WIDTH-1:0] scan_count
);

   localparam int EW = DATA_WIDTH + 1;
   localparam logic [DATA_WIDTH-1:0]  PH_ONE   = DATA_WIDTH'(1);
   localparam logic [EW-1:0]          EXT_ONE  = EW'(1);
   localparam logic [EW-1:0]          EXT_TWO  = EW'(2);
   localparam logic [EW-1:0]          EXT_FOUR = EW'(4);
   localparam logic [COUNT_WIDTH-1:0] CNT_ONE  = COUNT_WIDTH'(1);

   typedef enum logic {IDLE, RUN} state_t;

   state_t                 r_state, w_stateNext;
   logic [DATA_WIDTH-1:0]  r_phase, w_phaseNext;
   logic [DATA_WIDTH-1:0]  r_period, r_p0, r_p1, r_p2;
   logic                   r_hasCfg;
   logic [DATA_WIDTH-1:0]  r_pendPeriod, r_pendP0, r_pendP1, r_pendP2;
   logic                   r_pendValid;
   logic                   r_cfgError;
   logic                   r_expValid;
   logic [DATA_WIDTH-1:0]  r_expSm, r_expMm;
   logic [COUNT_WIDTH-1:0] r_scanCount;

   logic          w_accept, w_cfgOk, w_lastPhase, w_commit, w_expLoad, w_running;
   logic [EW-1:0] w_phaseExt;

   // Offsets are compared one bit wider so p+1..p+4 can never wrap past the period.
   assign w_running   = (r_state == RUN);
   assign w_phaseExt  = {1'b0, r_phase};
   assign w_accept    = cfg_valid && !r_pendValid;
   assign w_cfgOk     = (cfg_peak0 < cfg_peak1) && (cfg_peak1 < cfg_peak2) &&
                        (({1'b0, cfg_peak2} + EXT_FOUR) <= {1'b0, cfg_period});
   assign w_lastPhase = w_running && ((w_phaseExt + EXT_ONE) == {1'b0, r_period});
   assign w_commit    = r_pendValid && (!w_running || w_lastPhase);
   assign w_expLoad   = w_running && (w_phaseExt == ({1'b0, r_p2} + EXT_TWO));

   always_comb begin
      w_stateNext = r_state;
      w_phaseNext = '0;
      case (r_state)
         IDLE: begin
            if (enable && r_hasCfg) w_stateNext = RUN;
         end
         RUN: begin
            if (w_lastPhase) begin
               if (!enable || !r_hasCfg) w_stateNext = IDLE;
            end else begin
               w_phaseNext = r_phase + PH_ONE;
            end
         end
         default: w_stateNext = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_phase <= '0;
      end else begin
         r_state <= w_stateNext;
         r_phase <= w_phaseNext;
      end
   end

   // Pending config only reaches the active set between scans, never mid-scan.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_period     <= '0;
         r_p0         <= '0;
         r_p1         <= '0;
         r_p2         <= '0;
         r_hasCfg     <= 1'b0;
         r_pendPeriod <= '0;
         r_pendP0     <= '0;
         r_pendP1     <= '0;
         r_pendP2     <= '0;
         r_pendValid  <= 1'b0;
         r_cfgError   <= 1'b0;
      end else begin
         r_cfgError <= w_accept && !w_cfgOk;
         if (w_commit) begin
            r_period    <= r_pendPeriod;
            r_p0        <= r_pendP0;
            r_p1        <= r_pendP1;
            r_p2        <= r_pendP2;
            r_hasCfg    <= 1'b1;
            r_pendValid <= 1'b0;
         end
         if (w_accept && w_cfgOk) begin
            r_pendPeriod <= cfg_period;
            r_pendP0     <= cfg_peak0;
            r_pendP1     <= cfg_peak1;
            r_pendP2     <= cfg_peak2;
            r_pendValid  <= 1'b1;
         end
      end
   end

   // Loaded one cycle early so the values and the pulse are visible at phase p2+3.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_expValid  <= 1'b0;
         r_expSm     <= '0;
         r_expMm     <= '0;
         r_scanCount <= '0;
      end else begin
         r_expValid <= w_expLoad;
         if (w_expLoad) begin
            r_expSm     <= r_p1 - r_p0;
            r_expMm     <= r_p2 - r_p0;
            r_scanCount <= r_scanCount + CNT_ONE;
         end
      end
   end

   assign cfg_ready          = !r_pendValid;
   assign cfg_error          = r_cfgError;
   assign piezo_ramp_trigger = w_running && (r_phase == '0);
   assign peak_trigger       = w_running &&
                               ((w_phaseExt == ({1'b0, r_p0} + EXT_ONE)) ||
                                (w_phaseExt == ({1'b0, r_p1} + EXT_ONE)) ||
                                (w_phaseExt == ({1'b0, r_p2} + EXT_ONE)));
   assign exp_valid          = r_expValid;
   assign exp_sm_cycle       = r_expSm;
   assign exp_Mm_cycle       = r_expMm;
   assign scan_count         = r_scanCount;

endmodule

// File: tb/tb_scan_peak_emulator.sv
// Randomized bench for scan_peak_emulator: a cycle-level reference model of scan events
// is advanced alongside the design and every output is compared each cycle.
module tb_scan_peak_emulator;

   localparam int DW = 24;
   localparam int CW = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst, enable, cfgValid;
   logic [DW-1:0] cfgPeriod, cfgPeak0, cfgPeak1, cfgPeak2;
   logic          cfgReady, cfgError, rampTrig, peakTrig, expValid;
   logic [DW-1:0] expSm, expMm;
   logic [CW-1:0] scanCount;

   scan_peak_emulator #(.DATA_WIDTH(DW), .COUNT_WIDTH(CW)) dut (
      .clk                (clk),
      .rst                (rst),
      .enable             (enable),
      .cfg_valid          (cfgValid),
      .cfg_ready          (cfgReady),
      .cfg_period         (cfgPeriod),
      .cfg_peak0          (cfgPeak0),
      .cfg_peak1          (cfgPeak1),
      .cfg_peak2          (cfgPeak2),
      .cfg_error          (cfgError),
      .piezo_ramp_trigger (rampTrig),
      .peak_trigger       (peakTrig),
      .exp_sm_cycle       (expSm),
      .exp_Mm_cycle       (expMm),
      .exp_valid          (expValid),
      .scan_count         (scanCount)
   );

   int testCount = 0;
   int failCount = 0;

   // Model: whether a scan is in progress, its cycle index, and the config sets.
   bit mRun, mHas, mPendValid, mErr, mExpValid;
   int mPhase, mPeriod, mP0, mP1, mP2;
   int mPendPeriod, mPendP0, mPendP1, mPendP2;
   int mExpSm, mExpMm, mCount;

   task automatic checkOutput(input string tag, input logic [63:0] actual,
                              input logic [63:0] expected);
      testCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s at %0t: got %0d, expected %0d", tag, $time, actual, expected);
      end
   endtask

   function automatic bit cfgOk(input int per, input int p0, input int p1, input int p2);
      return (p0 < p1) && (p1 < p2) && (p2 + 4 <= per);
   endfunction

   task automatic modelReset();
      mRun = 0; mHas = 0; mPendValid = 0; mErr = 0; mExpValid = 0;
      mPhase = 0; mPeriod = 0; mP0 = 0; mP1 = 0; mP2 = 0;
      mPendPeriod = 0; mPendP0 = 0; mPendP1 = 0; mPendP2 = 0;
      mExpSm = 0; mExpMm = 0; mCount = 0;
   endtask

   // What the block reports in a cycle: the interval event lands at scan index p2+3.
   task automatic modelEvents();
      mExpValid = mRun && (mPhase == mP2 + 3);
      if (mExpValid) begin
         mExpSm  = mP1 - mP0;
         mExpMm  = mP2 - mP0;
         mCount  = (mCount + 1) % (1 << CW);
      end
   endtask

   // How the model moves on across one clock edge given the inputs currently driven.
   task automatic modelStep();
      bit accept, ok, boundary, commit;
      if (rst) begin
         modelReset();
         return;
      end
      accept   = cfgValid && !mPendValid;
      ok       = cfgOk(int'(cfgPeriod), int'(cfgPeak0), int'(cfgPeak1), int'(cfgPeak2));
      boundary = mRun && (mPhase == mPeriod - 1);
      commit   = mPendValid && (!mRun || boundary);
      mErr     = accept && !ok;
      if (!mRun) begin
         if (enable && mHas) begin
            mRun   = 1;
            mPhase = 0;
         end
      end else if (boundary) begin
         mPhase = 0;
         if (!enable) mRun = 0;
      end else begin
         mPhase++;
      end
      if (commit) begin
         mPeriod = mPendPeriod; mP0 = mPendP0; mP1 = mPendP1; mP2 = mPendP2;
         mHas = 1; mPendValid = 0;
      end
      if (accept && ok) begin
         mPendPeriod = int'(cfgPeriod); mPendP0 = int'(cfgPeak0);
         mPendP1 = int'(cfgPeak1); mPendP2 = int'(cfgPeak2);
         mPendValid = 1;
      end
   endtask

   task automatic checkCycle();
      bit expRamp, expPeak;
      expRamp = mRun && (mPhase == 0);
      expPeak = mRun && ((mPhase == mP0 + 1) || (mPhase == mP1 + 1) || (mPhase == mP2 + 1));
      checkOutput("ramp",      rampTrig,  expRamp);
      checkOutput("peak",      peakTrig,  expPeak);
      checkOutput("cfgReady",  cfgReady,  !mPendValid);
      checkOutput("cfgError",  cfgError,  mErr);
      checkOutput("expValid",  expValid,  mExpValid);
      checkOutput("expSm",     expSm,     mExpSm);
      checkOutput("expMm",     expMm,     mExpMm);
      checkOutput("scanCount", scanCount, mCount);
   endtask

   task automatic runCycle();
      checkCycle();
      modelStep();
      @(posedge clk);
      #1;
      modelEvents();
   endtask

   task automatic applyStimulus(input bit r, input bit en, input int cycles);
      rst      = r;
      enable   = en;
      cfgValid = 0;
      repeat (cycles) runCycle();
   endtask

   // Holds an offer until the handshake completes, with a bounded wait.
   task automatic offerConfig(input int per, input int p0, input int p1, input int p2);
      bit accepted;
      accepted  = 0;
      rst       = 0;
      cfgValid  = 1;
      cfgPeriod = DW'(per);
      cfgPeak0  = DW'(p0);
      cfgPeak1  = DW'(p1);
      cfgPeak2  = DW'(p2);
      for (int i = 0; i < 200 && !accepted; i++) begin
         accepted = !mPendValid;
         runCycle();
      end
      cfgValid = 0;
      checkOutput("offerAccepted", accepted, 1);
   endtask

   task automatic waitPhase(input int ph);
      for (int i = 0; i < 200; i++) begin
         if (mRun && mPhase == ph) break;
         runCycle();
      end
   endtask

   initial begin
      int kind, per, p0, p1, p2;
      rst = 1; enable = 0; cfgValid = 0;
      cfgPeriod = '0; cfgPeak0 = '0; cfgPeak1 = '0; cfgPeak2 = '0;
      modelStep();
      @(posedge clk);
      #1;
      modelEvents();
      applyStimulus(1, 0, 2);

      // Basic 20-cycle scan pattern, repeated.
      enable = 1;
      offerConfig(20, 2, 5, 9);
      applyStimulus(0, 1, 65);

      // Rejected offer must not disturb the running pattern.
      offerConfig(20, 4, 4, 9);
      applyStimulus(0, 1, 25);

      // New timing offered mid-scan, with a second offer queued behind it.
      waitPhase(4);
      offerConfig(30, 1, 10, 20);
      offerConfig(20, 2, 5, 9);
      applyStimulus(0, 1, 70);

      // Enable drop part-way through a scan.
      waitPhase(5);
      applyStimulus(0, 0, 40);

      // Reset mid-scan, then no scans until a fresh config arrives.
      applyStimulus(0, 1, 3);
      waitPhase(7);
      applyStimulus(1, 1, 1);
      applyStimulus(0, 1, 30);

      // Minimal period, back to back, long enough for the scan counter to wrap.
      offerConfig(6, 0, 1, 2);
      applyStimulus(0, 1, 120);

      // Validity boundaries, including sums that would wrap at DATA_WIDTH bits.
      applyStimulus(0, 0, 10);
      offerConfig(5, 0, 1, 2);
      applyStimulus(0, 0, 2);
      offerConfig(24'hFFFFFF, 0, 1, 24'hFFFFFD);
      applyStimulus(0, 0, 2);
      offerConfig(24'hFFFFFF, 0, 1, 24'hFFFFFB);
      applyStimulus(0, 0, 2);
      offerConfig(24, 3, 7, 19);
      applyStimulus(0, 0, 4);
      applyStimulus(0, 1, 60);

      // Random episodes.
      for (int ep = 0; ep < 60; ep++) begin
         kind = $urandom_range(0, 9);
         if (kind < 4) begin
            per = $urandom_range(4, 27);
            p0  = $urandom_range(0, 5);
            p1  = p0 + $urandom_range(0, 5);
            p2  = p1 + $urandom_range(0, 8);
            offerConfig(per, p0, p1, p2);
         end else if (kind < 7) begin
            applyStimulus(0, 1'($urandom_range(0, 1)), $urandom_range(1, 30));
         end else if (kind < 9) begin
            applyStimulus(0, 1, $urandom_range(10, 50));
         end else begin
            applyStimulus(1, 1'($urandom_range(0, 1)), 1);
         end
      end
      applyStimulus(0, 1, 40);

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule

// File: doc/scan_peak_emulator.md
# scan_peak_emulator

Scan-cycle stimulus generator for the cavity transfer-lock timing path. It produces the piezo ramp-start pulse and the three single-cycle peak pulses (m, s, M) that the peak-interval timer consumes. Pulses are placed at programmed clock-cycle offsets, and the block reports the intervals the timer must measure. It is used for in-system loopback/self-test and bench verification of the tau_A/tau_B error-signal chain without a live piezo or photodiode.

## Interface
- DATA_WIDTH, 24, width of period, offsets and expected-interval outputs
- COUNT_WIDTH, 16, width of completed-scan counter
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- enable  in  1  run scans while high
- cfg_valid  in  1  config offer
- cfg_ready  out  1  config slot free
- cfg_period  in  DATA_WIDTH  scan length in cycles
- cfg_peak0 / cfg_peak1 / cfg_peak2  in  DATA_WIDTH each  offsets of peaks m, s, M
- cfg_error  out  1  one-cycle pulse: offered config rejected
- piezo_ramp_trigger  out  1  one-cycle ramp-start pulse
- peak_trigger  out  1  one-cycle peak pulse
- exp_sm_cycle  out  DATA_WIDTH  expected tau_A = peak1 - peak0
- exp_Mm_cycle  out  DATA_WIDTH  expected tau_B = peak2 - peak0
- exp_valid  out  1  one-cycle pulse: timer outputs now reflect the finished scan
- scan_count  out  COUNT_WIDTH  completed scans, wraps

## Operation
- Registers:
  - active config (period, p0, p1, p2), has_cfg
  - one pending slot (pend_*, pend_valid)
  - phase counter, DATA_WIDTH bits
- FSM states: IDLE and RUN.
  - IDLE -> RUN when enable && has_cfg. The first RUN cycle is phase 0.
  - RUN -> IDLE at phase == period-1 if enable is low or the active config becomes invalid. The current scan always completes.
- Phase counts 0..period-1 in RUN, then wraps to 0.
- Outputs in RUN:
  - piezo_ramp_trigger = 1 at phase 0.
  - peak_trigger = 1 at phase p0+1, p1+1, p2+1. The +1 matches the timer, whose counter reads 0 the cycle after the ramp pulse.
  - Both are 0 in all other cycles and always 0 in IDLE.
- Config handshake:
  - Transfer on cfg_valid && cfg_ready.
  - cfg_ready = !pend_valid.
  - Validity rule: p0 < p1 < p2 and p2+4 <= period. Compute in DATA_WIDTH+1 bits; no wrap.
  - Invalid offer: dropped, cfg_error pulses the next cycle, active and pending configs unchanged.
  - Valid offer: loaded into the pending slot.
  - Pending slot commits to active in any IDLE cycle, or at phase == period-1 in RUN. It therefore takes effect at the next ramp and never mid-scan. Commit sets has_cfg and clears pend_valid.
- Expected intervals:
  - exp_sm_cycle and exp_Mm_cycle are registered from the active config at phase p2+3.
  - exp_valid pulses in that same cycle.
  - scan_count increments in that same cycle.
- Reset:
  - All outputs 0; scan_count 0; exp_* 0.
  - has_cfg = 0, pend_valid = 0, FSM IDLE.
  - Applies mid-scan too: pulses stop from the cycle after rst is sampled high.

## Timing
- The ramp pulse must fall in a cycle where the timer's hold is clear. The p2+4 <= period rule guarantees this:
  - peak at p2+1;
  - timer sees peak_trigger low at p2+2 and clears hold at that edge;
  - next ramp no earlier than phase p2+3 relative to this scan.
- Latency:
  - IDLE->RUN: ramp pulse in the cycle after enable && has_cfg is sampled.
  - Config accepted in IDLE: commits next cycle; first ramp one cycle after commit.
- Simultaneous events:
  - Offer accepted in the cycle at phase == period-1 with pend_valid low: it lands in pending and commits at the next boundary, not this one.
  - enable low and pending commit at the same boundary: commit still happens, then IDLE.
- Peak pulses never overlap the ramp pulse; guaranteed by p0 >= 0 and p2+1 < period.

## Test plan
- Reset, offer period=20/p0=2/p1=5/p2=9, enable=1 -> ramp at phase 0; peaks at phases 3, 6, 10; exp_valid at phase 12 with exp_sm=3, exp_Mm=7; repeats every 20 cycles; scan_count 1, 2, 3…
- Offer p0=4, p1=4 -> cfg_error pulse one cycle later; no handshake into pending; the previous scan pattern continues unchanged.
- Offer period=30/p0=1/p1=10/p2=20 mid-scan -> current scan keeps the old timing; cfg_ready low until boundary; next ramp uses new offsets; exp_sm=9, exp_Mm=19.
- Drop enable at phase 5 of a 20-cycle scan -> remaining peaks and exp_valid still occur; no ramp at the next phase 0; block idle.
- Assert rst at phase 7 -> from the next cycle, no peak or ramp pulses; all outputs 0; no scans until a new config is accepted.
- Minimal period=p2+4 (p0=0, p1=1, p2=2, period=6), back-to-back scans with the timer in loopback -> timer tau_A=1, tau_B=2 every scan; COUNT_WIDTH=4 wraps 15 -> 0.
